divider_nbit: RTL and testbench
===============================

# divider_nbit

Multi-cycle N-bit integer divider for the execute stage, covering RISC-V DIV/DIVU/REM/REMU. It produces quotient and remainder by restoring division, one quotient bit per clock. Each step's trial subtraction is a `full_adder_nbit #(N+1)` instance fed the one's complement of the divisor with carry-in 1. The pipeline stalls on `o_busy` and consumes results on the `o_valid` pulse.

## Interface
- `N`, default 32: operand and result width; N ≥ 2.
- `i_clk` input 1: clock; all state changes on the rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_start` input 1: request; sampled only in IDLE.
- `i_signed` input 1: 1 = signed two's-complement (DIV/REM), 0 = unsigned (DIVU/REMU).
- `i_dividend` input N: dividend; captured with `i_start`.
- `i_divisor` input N: divisor; captured with `i_start`.
- `i_flush` input 1: abort the current operation; no result is produced.
- `o_busy` output 1: high while an operation is in flight (CALC or FIX).
- `o_valid` output 1: one-cycle pulse; results are valid in that cycle.
- `o_quotient` output N: quotient.
- `o_remainder` output N: remainder.
- `o_div_by_zero` output 1: qualifies `o_valid`; the divisor was 0.

## Operation
- States: IDLE, CALC, FIX.
- Reset values: state = IDLE; `o_busy`, `o_valid`, `o_div_by_zero` = 0; `o_quotient`, `o_remainder` = 0.
- **IDLE**
  - On `i_start` = 1 and `i_flush` = 0, latch operands and `i_signed`.
  - In signed mode, convert each operand to its magnitude. Record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Clear the partial remainder R (N bits) and set the step counter to N-1.
  - Divisor == 0: go to FIX with quotient = all ones and remainder = raw dividend. This overrides signed mode (no sign fix).
  - Signed dividend == 2^(N-1) and divisor == all ones: go to FIX with quotient = 2^(N-1) and remainder = 0.
  - Otherwise go to CALC.
- **CALC** (one step per cycle, dividend bits MSB first)
  - T = {R, next dividend bit}, N+1 bits.
  - D = T + ~{0, divisor} + 1.
  - Carry-out 1: R ← D[N-1:0] and the quotient bit is 1.
  - Carry-out 0: R ← T[N-1:0] and the quotient bit is 0.
  - Quotient bits shift into the dividend register, which is reused as the quotient register.
  - Counter == 0: go to FIX; otherwise decrement.
- **FIX**
  - Apply signs: negate the quotient if sign_q; negate the remainder if sign_r. Special-case results bypass this.
  - Register the outputs, pulse `o_valid`, set `o_div_by_zero` for the divide-by-zero case, and go to IDLE.
- Outputs hold their last result until the next FIX; they are not cleared between operations.
- `i_flush`
  - In CALC or FIX: go to IDLE next edge. `o_valid` stays 0 and outputs are unchanged.
  - Simultaneous with `i_start` in IDLE: flush wins and the start is dropped.
- `i_start` while `o_busy` = 1 is ignored. The requester must hold its request until it sees `o_busy` = 0.
- Reset asserted mid-operation: immediate return to the reset values; the result is lost.

## Timing
- Let E0 be the edge that samples `i_start`.
- Normal case:
  - `o_busy` = 1 from E0 through E(N+1).
  - CALC occupies edges E1..EN.
  - FIX registers the results at E(N+1).
  - `o_valid` = 1 for the cycle after E(N+1), with `o_busy` = 0 in that same cycle.
  - Latency: N+2 edges (34 for N = 32).
- Special cases (divide-by-zero, signed overflow): FIX at E1, `o_valid` in the cycle after E1. Latency: 2 edges.
- Back-to-back: a new `i_start` can be sampled at the edge that ends the `o_valid` cycle.
- `o_valid` never stays high for two consecutive cycles.

## Test plan
- Unsigned, N = 32: 100 / 7 → q = 14, r = 2, `o_valid` exactly 34 edges after start, `o_busy` high for 33 cycles.
- Signed: -7 / 2 → q = -3 (0xFFFFFFFD), r = -1. Also 7 / -2 → q = -3, r = 1; and 0xFFFFFFF9 / 2 unsigned → q = 0x7FFFFFFC, r = 1.
- Divide by zero: 0x12345678 / 0 (both modes) → q = 0xFFFFFFFF, r = 0x12345678, `o_div_by_zero` = 1, `o_valid` 2 edges after start.
- Signed overflow: 0x80000000 / 0xFFFFFFFF → q = 0x80000000, r = 0, latency 2. The same operands unsigned → q = 0, r = 0x80000000, latency 34.
- Flush and reset: `i_flush` at step 10 → no `o_valid`, `o_busy` low next cycle, prior outputs unchanged, and a following 9 / 3 gives q = 3, r = 0. `i_rst_n` low mid-CALC → all outputs 0 immediately.
- Back-to-back and ignored start: two starts spaced exactly 34 edges apart both complete. A start pulsed mid-operation is ignored, and exactly one `o_valid` is seen.

Source files
------------

// File: rtl/divider_nbit.sv
// Multi-cycle restoring divider for RISC-V DIV/DIVU/REM/REMU, one quotient bit per clock.
// Also holds the ripple-carry adder that performs each step's trial subtraction.

module full_adder_nbit #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_cin,
   output logic [N-1:0] o_sum,
   output logic         o_cout
);

   logic [N:0] carry;

   always_comb begin
      carry    = '0;
      carry[0] = i_cin;
      o_sum    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         o_sum[i]     = i_a[i] ^ i_b[i] ^ carry[i];
         carry[i + 1] = (i_a[i] & i_b[i]) | (carry[i] & (i_a[i] ^ i_b[i]));
      end
      o_cout = carry[N];
   end

endmodule

module divider_nbit #(
   parameter int unsigned N = 32
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic         i_signed,
   input  logic [N-1:0] i_dividend,
   input  logic [N-1:0] i_divisor,
   input  logic         i_flush,
   output logic         o_busy,
   output logic         o_valid,
   output logic [N-1:0] o_quotient,
   output logic [N-1:0] o_remainder,
   output logic         o_div_by_zero
);

   localparam int unsigned CW = $clog2(N);
   localparam logic [N-1:0] MIN_NEG = {1'b1, {(N - 1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX
   } state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  dvd_q, dvd_d;       // dividend in, quotient bits shift in from the LSB
   logic [N-1:0]  dvs_q, dvs_d;
   logic [N-1:0]  rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          qneg_q, qneg_d;
   logic          rneg_q, rneg_d;
   logic          special_q, special_d;
   logic          dbz_q, dbz_d;
   logic [N-1:0]  quo_out_q, quo_out_d;
   logic [N-1:0]  rem_out_q, rem_out_d;
   logic          valid_q, valid_d;
   logic          dbz_out_q, dbz_out_d;

   logic [N:0]    trial;
   logic [N:0]    sub_b;
   logic [N:0]    diff;
   logic          diff_cout;
   logic          a_neg, b_neg;

   function automatic logic [N-1:0] twos_neg(input logic [N-1:0] v);
      return ~v + {{(N - 1){1'b0}}, 1'b1};
   endfunction

   assign trial = {rem_q, dvd_q[N-1]};
   assign sub_b = ~{1'b0, dvs_q};

   full_adder_nbit #(
      .N(N + 1)
   ) u_trial_sub (
      .i_a   (trial),
      .i_b   (sub_b),
      .i_cin (1'b1),
      .o_sum (diff),
      .o_cout(diff_cout)
   );

   always_comb begin
      state_d   = state_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      special_d = special_q;
      dbz_d     = dbz_q;
      quo_out_d = quo_out_q;
      rem_out_d = rem_out_q;
      valid_d   = 1'b0;
      dbz_out_d = dbz_out_q;
      a_neg     = i_signed & i_dividend[N-1];
      b_neg     = i_signed & i_divisor[N-1];

      unique case (state_q)
         S_IDLE: begin
            if (i_start && !i_flush) begin
               dvd_d     = a_neg ? twos_neg(i_dividend) : i_dividend;
               dvs_d     = b_neg ? twos_neg(i_divisor) : i_divisor;
               rem_d     = '0;
               cnt_d     = CW'(N - 1);
               qneg_d    = a_neg ^ b_neg;
               rneg_d    = a_neg;
               special_d = 1'b0;
               dbz_d     = 1'b0;
               // Special cases preload the final result and skip CALC and the sign fix.
               if (i_divisor == '0) begin
                  state_d   = S_FIX;
                  special_d = 1'b1;
                  dbz_d     = 1'b1;
                  dvd_d     = '1;
                  rem_d     = i_dividend;
               end else if (i_signed && (i_dividend == MIN_NEG) && (i_divisor == '1)) begin
                  state_d   = S_FIX;
                  special_d = 1'b1;
                  dvd_d     = MIN_NEG;
                  rem_d     = '0;
               end else begin
                  state_d = S_CALC;
               end
            end
         end

         S_CALC: begin
            if (i_flush) begin
               state_d = S_IDLE;
            end else begin
               rem_d = diff_cout ? diff[N-1:0] : trial[N-1:0];
               dvd_d = {dvd_q[N-2:0], diff_cout};
               if (cnt_q == '0) begin
                  state_d = S_FIX;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end

         S_FIX: begin
            if (i_flush) begin
               state_d = S_IDLE;
            end else begin
               quo_out_d = (!special_q && qneg_q) ? twos_neg(dvd_q) : dvd_q;
               rem_out_d = (!special_q && rneg_q) ? twos_neg(rem_q) : rem_q;
               dbz_out_d = dbz_q;
               valid_d   = 1'b1;
               state_d   = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         special_q <= 1'b0;
         dbz_q     <= 1'b0;
         quo_out_q <= '0;
         rem_out_q <= '0;
         valid_q   <= 1'b0;
         dbz_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         special_q <= special_d;
         dbz_q     <= dbz_d;
         quo_out_q <= quo_out_d;
         rem_out_q <= rem_out_d;
         valid_q   <= valid_d;
         dbz_out_q <= dbz_out_d;
      end
   end

   assign o_busy        = (state_q != S_IDLE);
   assign o_valid       = valid_q;
   assign o_quotient    = quo_out_q;
   assign o_remainder   = rem_out_q;
   assign o_div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_divider_nbit.sv
// Directed-vector bench for divider_nbit (N = 32): arithmetic, latency, special cases,
// flush, reset, back-to-back and ignored starts.

module tb_divider_nbit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        sgn;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        flush;
   logic        busy;
   logic        valid;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        dbz;

   int n_cmp;
   int n_err;

   divider_nbit #(
      .N(32)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_signed     (sgn),
      .i_dividend   (dividend),
      .i_divisor    (divisor),
      .i_flush      (flush),
      .o_busy       (busy),
      .o_valid      (valid),
      .o_quotient   (quotient),
      .o_remainder  (remainder),
      .o_div_by_zero(dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called ~1 time unit after a rising edge; start is sampled at the next edge (E0).
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
      dividend = a;
      divisor  = b;
      sgn      = s;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Latency counts E0 as edge 1; returns in the o_valid cycle.
   task automatic wait_done(output int lat, output int busy_n);
      lat    = 1;
      busy_n = 0;
      while (!valid && lat < 100) begin
         if (busy) busy_n++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic exp_dbz, input int exp_lat);
      int lat, busy_n;
      launch(a, b, s);
      wait_done(lat, busy_n);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_q"}, 64'(quotient), 64'(exp_q));
      check({tag, "_r"}, 64'(remainder), 64'(exp_r));
      check({tag, "_dbz"}, 64'(dbz), 64'(exp_dbz));
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, 64'(valid), 64'(0));
   endtask

   initial begin
      int lat, busy_n, vcnt;
      n_cmp    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      sgn      = 1'b0;
      dividend = '0;
      divisor  = '0;
      flush    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_q", 64'(quotient), 64'(0));
      check("rst_r", 64'(remainder), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_valid", 64'(valid), 64'(0));
      check("rst_dbz", 64'(dbz), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 100 / 7 unsigned with busy-window measurement
      launch(32'd100, 32'd7, 1'b0);
      wait_done(lat, busy_n);
      check("u100_lat", 64'(lat), 64'(34));
      check("u100_busyn", 64'(busy_n), 64'(33));
      check("u100_busy_at_valid", 64'(busy), 64'(0));
      check("u100_q", 64'(quotient), 64'(14));
      check("u100_r", 64'(remainder), 64'(2));
      @(posedge clk);
      #1;
      check("u100_pulse", 64'(valid), 64'(0));

      run_op("sneg7", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
      run_op("s7neg2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
      run_op("uF9", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 34);
      run_op("sneg100", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0, 34);
      run_op("udbz", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 2);
      run_op("sdbz", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 2);
      run_op("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 2);
      run_op("uovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 34);

      // Flush at step 10: outputs keep the uovf result
      launch(32'd100, 32'd7, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_busy", 64'(busy), 64'(0));
      check("flush_valid", 64'(valid), 64'(0));
      check("flush_q_hold", 64'(quotient), 64'(0));
      check("flush_r_hold", 64'(remainder), 64'(32'h8000_0000));
      vcnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (valid) vcnt++;
      end
      check("flush_no_valid", 64'(vcnt), 64'(0));
      run_op("u9by3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34);

      // Start together with flush in IDLE is dropped
      dividend = 32'd50;
      divisor  = 32'd5;
      sgn      = 1'b0;
      start    = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      check("startflush_busy", 64'(busy), 64'(0));

      // Back-to-back: second start sampled at the edge ending the first o_valid cycle
      launch(32'd100, 32'd7, 1'b0);
      wait_done(lat, busy_n);
      check("b2b_a_lat", 64'(lat), 64'(34));
      check("b2b_a_q", 64'(quotient), 64'(14));
      launch(32'd1000, 32'd9, 1'b0);
      wait_done(lat, busy_n);
      check("b2b_b_lat", 64'(lat), 64'(34));
      check("b2b_b_q", 64'(quotient), 64'(111));
      check("b2b_b_r", 64'(remainder), 64'(1));
      @(posedge clk);
      #1;

      // Start pulsed mid-operation is ignored
      launch(32'd100, 32'd7, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      dividend = 32'd50;
      divisor  = 32'd5;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = 32'd0;
      divisor  = 32'd0;
      wait_done(lat, busy_n);
      check("ign_lat", 64'(lat), 64'(28));
      check("ign_q", 64'(quotient), 64'(14));
      check("ign_r", 64'(remainder), 64'(2));
      vcnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (valid) vcnt++;
      end
      check("ign_one_valid", 64'(vcnt), 64'(0));

      // Reset mid-CALC clears everything immediately
      launch(32'd100, 32'd7, 1'b0);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("mrst_q", 64'(quotient), 64'(0));
      check("mrst_r", 64'(remainder), 64'(0));
      check("mrst_busy", 64'(busy), 64'(0));
      check("mrst_valid", 64'(valid), 64'(0));
      check("mrst_dbz", 64'(dbz), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op("post_rst", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
